// File: rtl/loproc_mul_result_buffer_pkg.sv
// Shared constants and phase type for the multiplier result buffer.
// LOPROC_MRB_HI_WRITE_EN selects two-beat (low then high half) writeback.
package loproc_mul_result_buffer_pkg;

  localparam int unsigned MRB_DATA_WIDTH = 32;
  localparam int unsigned MRB_DEPTH      = 4;

`ifdef LOPROC_MRB_HI_WRITE_EN
  localparam bit MRB_HI_EN = 1'b1;
`else
  localparam bit MRB_HI_EN = 1'b0;
`endif

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } mrb_phase_e;

  function automatic int unsigned mrb_entry_width(input int unsigned dw, input bit hi_en);
    return hi_en ? 2 * dw : dw;
  endfunction

endpackage

// File: rtl/loproc_sync_fifo.sv
// Parameterised synchronous FIFO, async active-low reset, storage cleared on reset.
// Caller guarantees no push when full without a pop, and no pop when empty.
module loproc_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/loproc_mul_result_buffer.sv
// Buffers multiplier products and serialises them to the writeback port.
// LOPROC_MRB_HI_WRITE_EN: defined = low then high beat per entry; undefined = low beat only.
module loproc_mul_result_buffer
  import loproc_mul_result_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = MRB_DEPTH,
  parameter int unsigned DATA_WIDTH = MRB_DATA_WIDTH
) (
  input  logic                   mrb_clk,
  input  logic                   mrb_rst_n,
  input  logic                   valid_in,
  input  logic [DATA_WIDTH-1:0]  in_l,
  input  logic [DATA_WIDTH-1:0]  in_h,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [DATA_WIDTH-1:0]  wb_data,
  output logic                   wb_hi,
  output logic                   wb_last
);

  localparam int unsigned ENTRY_W = mrb_entry_width(DATA_WIDTH, MRB_HI_EN);

  logic               beat;
  logic               push;
  logic               pop;
  logic               empty;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] head;

  assign beat     = wb_valid && wb_ready;
  assign push     = valid_in && (!full || pop);
  assign wb_valid = !empty;

`ifdef LOPROC_MRB_HI_WRITE_EN
  mrb_phase_e phase;

  assign entry   = {in_h, in_l};
  assign pop     = beat && (phase == PH_HI);
  assign wb_data = (phase == PH_HI) ? head[ENTRY_W-1:DATA_WIDTH] : head[DATA_WIDTH-1:0];

  // wb_hi/wb_last are registered alongside the phase so they only move on a beat.
  always_ff @(posedge mrb_clk or negedge mrb_rst_n) begin
    if (!mrb_rst_n) begin
      phase   <= PH_LO;
      wb_hi   <= 1'b0;
      wb_last <= 1'b0;
    end else if (beat) begin
      case (phase)
        PH_LO: begin
          phase   <= PH_HI;
          wb_hi   <= 1'b1;
          wb_last <= 1'b1;
        end
        default: begin
          phase   <= PH_LO;
          wb_hi   <= 1'b0;
          wb_last <= 1'b0;
        end
      endcase
    end
  end
`else
  logic unused_in_h;

  assign unused_in_h = ^in_h;
  assign entry       = in_l;
  assign pop         = beat;
  assign wb_data     = head;
  assign wb_hi       = 1'b0;
  assign wb_last     = 1'b1;
`endif

  always_ff @(posedge mrb_clk or negedge mrb_rst_n) begin
    if (!mrb_rst_n)                   overflow <= 1'b0;
    else if (valid_in && full && !pop) overflow <= 1'b1;
  end

  loproc_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (mrb_clk),
    .rst_n (mrb_rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (entry),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_loproc_mul_result_buffer.sv
// Self-checking bench for loproc_mul_result_buffer (works with or without LOPROC_MRB_HI_WRITE_EN).
module tb_loproc_mul_result_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

`ifdef LOPROC_MRB_HI_WRITE_EN
  localparam logic LO_LAST = 1'b0;
`else
  localparam logic LO_LAST = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] in_l = '0;
  logic [DW-1:0] in_h = '0;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [DW-1:0] wb_data;
  logic          wb_hi;
  logic          wb_last;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  loproc_mul_result_buffer #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW)
  ) dut (
    .mrb_clk   (clk),
    .mrb_rst_n (rst_n),
    .valid_in  (valid_in),
    .in_l      (in_l),
    .in_h      (in_h),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .wb_hi     (wb_hi),
    .wb_last   (wb_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] h;
    logic          rdy_on_push;
    logic [DW-1:0] exp_lo;
    logic [DW-1:0] exp_hi;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string name, input logic [DW-1:0] d, input logic hi, input logic last);
    check({name, " wb_valid"}, 64'(wb_valid), 64'(1'b1));
    check({name, " wb_data"},  64'(wb_data),  64'(d));
    check({name, " wb_hi"},    64'(wb_hi),    64'(hi));
    check({name, " wb_last"},  64'(wb_last),  64'(last));
  endtask

  // Expects the head entry on the port and consumes it with wb_ready high.
  task automatic drain_entry(input string name, input logic [DW-1:0] l, input logic [DW-1:0] h);
    wb_ready = 1'b1;
    expect_beat({name, " lo"}, l, 1'b0, LO_LAST);
`ifdef LOPROC_MRB_HI_WRITE_EN
    tick();
    expect_beat({name, " hi"}, h, 1'b1, 1'b1);
`else
    if (h !== h) $display("unreachable");
`endif
    tick();
  endtask

  task automatic push_one(input logic [DW-1:0] l, input logic [DW-1:0] h);
    in_l     = l;
    in_h     = h;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    wb_ready = 1'b0;
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #12;
    rst_n    = 1'b1;
    tick();
  endtask

  task automatic check_empty(input string name);
    check({name, " count"},    64'(count),    64'(0));
    check({name, " wb_valid"}, 64'(wb_valid), 64'(0));
  endtask

  initial begin
    vecs[0] = '{l: 32'h04BEE0FE, h: 32'h00000000, rdy_on_push: 1'b1, exp_lo: 32'h04BEE0FE, exp_hi: 32'h00000000};
    vecs[1] = '{l: 32'hFF00BFF1, h: 32'hFE228E56, rdy_on_push: 1'b0, exp_lo: 32'hFF00BFF1, exp_hi: 32'hFE228E56};
    vecs[2] = '{l: 32'hFFFFFFFF, h: 32'hFFFFFFFF, rdy_on_push: 1'b1, exp_lo: 32'hFFFFFFFF, exp_hi: 32'hFFFFFFFF};
    vecs[3] = '{l: 32'h00000000, h: 32'h80000001, rdy_on_push: 1'b0, exp_lo: 32'h00000000, exp_hi: 32'h80000001};
    vecs[4] = '{l: 32'h12345678, h: 32'h9ABCDEF0, rdy_on_push: 1'b1, exp_lo: 32'h12345678, exp_hi: 32'h9ABCDEF0};

    // Reset values
    #3;
    check("rst count",    64'(count),    64'(0));
    check("rst full",     64'(full),     64'(0));
    check("rst overflow", 64'(overflow), 64'(0));
    check("rst wb_valid", 64'(wb_valid), 64'(0));
    check("rst wb_hi",    64'(wb_hi),    64'(0));
    check("rst wb_last",  64'(wb_last),  64'(LO_LAST));
    check("rst wb_data",  64'(wb_data),  64'(0));
    #9;
    rst_n = 1'b1;
    tick();
    wb_ready = 1'b1;
    tick();
    check_empty("empty ready ignored");

    // Single products, ready either high (ignored while empty) or low during push
    for (int i = 0; i < 5; i++) begin
      wb_ready = vecs[i].rdy_on_push;
      push_one(vecs[i].l, vecs[i].h);
      check($sformatf("vec%0d count", i), 64'(count), 64'(1));
      drain_entry($sformatf("vec%0d", i), vecs[i].exp_lo, vecs[i].exp_hi);
      wb_ready = 1'b0;
      check_empty($sformatf("vec%0d after", i));
    end

    // Back-pressure: payload holds stable while stalled
    push_one(32'hFF00BFF1, 32'hFE228E56);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp hold%0d data", c), 64'(wb_data), 64'(32'hFF00BFF1));
      check($sformatf("bp hold%0d valid", c), 64'(wb_valid), 64'(1));
      check($sformatf("bp hold%0d hi", c), 64'(wb_hi), 64'(0));
      tick();
    end
    drain_entry("bp", 32'hFF00BFF1, 32'hFE228E56);
    wb_ready = 1'b0;
    check_empty("bp after");

    // Full boundary: push alongside final-beat pop keeps count at DEPTH
    do_reset();
    for (int i = 0; i < 4; i++) push_one(32'(10 + i), 32'(32'h100 + 10 + i));
    check("fb count full", 64'(count), 64'(4));
    check("fb full",       64'(full),  64'(1));
`ifdef LOPROC_MRB_HI_WRITE_EN
    wb_ready = 1'b1;
    tick();
    check("fb in PH_HI", 64'(wb_hi), 64'(1));
`endif
    wb_ready = 1'b1;
    push_one(32'd14, 32'h10E);
    check("fb count held", 64'(count),    64'(4));
    check("fb full held",  64'(full),     64'(1));
    check("fb no ovf",     64'(overflow), 64'(0));
    for (int i = 0; i < 4; i++) drain_entry($sformatf("fb e%0d", i), 32'(11 + i), 32'(32'h100 + 11 + i));
    wb_ready = 1'b0;
    check_empty("fb after");
    check("fb no ovf end", 64'(overflow), 64'(0));

`ifdef LOPROC_MRB_HI_WRITE_EN
    // Push alongside a non-final beat while full is dropped
    for (int i = 0; i < 4; i++) push_one(32'(20 + i), 32'(32'h200 + i));
    wb_ready = 1'b1;
    push_one(32'd99, 32'd99);
    check("nf count", 64'(count),    64'(4));
    check("nf ovf",   64'(overflow), 64'(1));
    do_reset();
`endif

    // Overflow: five pushes into a four-entry buffer with no drain
    for (int i = 1; i <= 5; i++) begin
      push_one(32'(i), 32'(32'h100 + i));
      if (i == 4) begin
        check("ovf full@4", 64'(full),     64'(1));
        check("ovf flag@4", 64'(overflow), 64'(0));
      end
    end
    check("ovf flag@5",  64'(overflow), 64'(1));
    check("ovf count@5", 64'(count),    64'(4));
    for (int i = 1; i <= 4; i++) drain_entry($sformatf("ovf e%0d", i), 32'(i), 32'(32'h100 + i));
    wb_ready = 1'b0;
    check_empty("ovf after");
    check("ovf sticky", 64'(overflow), 64'(1));

    // Reset mid-operation
    do_reset();
    check("rst clears ovf", 64'(overflow), 64'(0));
    push_one(32'hAAAA0001, 32'hBBBB0001);
    push_one(32'hAAAA0002, 32'hBBBB0002);
`ifdef LOPROC_MRB_HI_WRITE_EN
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check("mid in PH_HI", 64'(wb_hi), 64'(1));
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check_empty("mid async");
    check("mid wb_hi",   64'(wb_hi),   64'(0));
    check("mid wb_last", 64'(wb_last), 64'(LO_LAST));
    check("mid wb_data", 64'(wb_data), 64'(0));
    #10;
    rst_n = 1'b1;
    tick();
    check_empty("mid post");
    push_one(32'hCCCC0003, 32'hDDDD0003);
    drain_entry("mid new", 32'hCCCC0003, 32'hDDDD0003);
    wb_ready = 1'b0;
    check_empty("mid new after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
